seq_divider_byte_io: RTL and testbench

- Sequential unsigned restoring divider, radix-2, one quotient bit per clock.
- Inverse companion to the team's radix-4 Booth multiplier. Same byte-serial operand loading over an 8-bit bus; 16-bit results returned in halves.
- Sits behind the same byte-wide host/switch interface, with its own controller FSM.

---
 rtl/seq_divider_byte_io_if.sv | 26 ++
 rtl/seq_divider_byte_io.sv | 155 +++++++++++++++
 tb/tb_seq_divider_byte_io.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_byte_io_if.sv
// Byte-serial operand bus and half-width result handshake for seq_divider_byte_io.
// signed_mode exists only when SEQ_DIVIDER_SIGNED_EN is defined.
interface seq_divider_byte_io_if #(parameter int WIDTH = 16);
   logic             start;
   logic             in_valid;
   logic [7:0]       in;
   logic             out_ack;
   logic             busy;
   logic             out_valid;
   logic             out_is_rem;
   logic [WIDTH-1:0] out;
   logic             div_by_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
   logic             signed_mode;

   modport master (output start, in_valid, in, out_ack, signed_mode,
                   input  busy, out_valid, out_is_rem, out, div_by_zero);
   modport slave  (input  start, in_valid, in, out_ack, signed_mode,
                   output busy, out_valid, out_is_rem, out, div_by_zero);
`else
   modport master (output start, in_valid, in, out_ack,
                   input  busy, out_valid, out_is_rem, out, div_by_zero);
   modport slave  (input  start, in_valid, in, out_ack,
                   output busy, out_valid, out_is_rem, out, div_by_zero);
`endif
endinterface

// File: rtl/seq_divider_byte_io.sv
// Radix-2 restoring divider, byte-serial load, WIDTH cycles/op (+1 FIXUP with SEQ_DIVIDER_SIGNED_EN);
// input gaps stall LOAD, results hold on out until out_ack, quotient half first then remainder.
module seq_divider_byte_io #(
   parameter int WIDTH = 16
) (
   input logic                 clk,
   input logic                 rst,
   seq_divider_byte_io_if.slave bus
);
   localparam int NBYTES = 2 * WIDTH / 8;
   localparam int BCW    = $clog2(NBYTES + 1);
   localparam int ICW    = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CALC,
`ifdef SEQ_DIVIDER_SIGNED_EN
      FIXUP,
`endif
      OUT_Q,
      OUT_R
   } state_t;

   state_t             state;
   logic [2*WIDTH-1:0] operands;
   logic [WIDTH-1:0]   q;
   // Top bit of the partial remainder is always 0 once stored, so only WIDTH bits are kept.
   logic [WIDTH-1:0]   r;
   logic [BCW-1:0]     byte_cnt;
   logic [ICW-1:0]     iter_cnt;
`ifdef SEQ_DIVIDER_SIGNED_EN
   logic               signed_q;
   logic [WIDTH-1:0]   q_fix;
   logic [WIDTH-1:0]   r_fix;
`endif

   logic [WIDTH-1:0]   dividend;
   logic [WIDTH-1:0]   divisor;
   logic [WIDTH-1:0]   dividend_in;
   logic [WIDTH-1:0]   d_mag;
   logic [WIDTH-1:0]   q_init;
   logic [WIDTH-1:0]   q_step;
   logic [WIDTH-1:0]   r_step;
   logic [WIDTH:0]     trial;

   always_comb begin
      dividend    = operands[WIDTH-1:0];
      divisor     = operands[2*WIDTH-1:WIDTH];
      // Dividend position at the moment the final divisor byte is shifted in.
      dividend_in = operands[WIDTH+7:8];
      d_mag       = divisor;
      q_init      = dividend_in;
`ifdef SEQ_DIVIDER_SIGNED_EN
      if (signed_q && divisor[WIDTH-1])     d_mag  = -divisor;
      if (signed_q && dividend_in[WIDTH-1]) q_init = -dividend_in;
      q_fix = (dividend[WIDTH-1] ^ divisor[WIDTH-1]) ? -q : q;
      r_fix = dividend[WIDTH-1] ? -r : r;
`endif
      trial = {r, q[WIDTH-1]} - {1'b0, d_mag};
      if (!trial[WIDTH]) begin
         r_step = trial[WIDTH-1:0];
         q_step = {q[WIDTH-2:0], 1'b1};
      end else begin
         r_step = {r[WIDTH-2:0], q[WIDTH-1]};
         q_step = {q[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         operands        <= '0;
         q               <= '0;
         r               <= '0;
         byte_cnt        <= '0;
         iter_cnt        <= '0;
         bus.busy        <= 1'b0;
         bus.out_valid   <= 1'b0;
         bus.out_is_rem  <= 1'b0;
         bus.out         <= '0;
         bus.div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         signed_q        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               state           <= LOAD;
               byte_cnt        <= '0;
               operands        <= '0;
               bus.div_by_zero <= 1'b0;
               bus.busy        <= 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
               signed_q        <= bus.signed_mode;
`endif
            end
            LOAD: if (bus.in_valid) begin
               operands <= {bus.in, operands[2*WIDTH-1:8]};
               byte_cnt <= byte_cnt + 1'b1;
               if (byte_cnt == BCW'(NBYTES - 1)) begin
                  state    <= CALC;
                  r        <= '0;
                  q        <= q_init;
                  iter_cnt <= '0;
               end
            end
            CALC: if (divisor == '0) begin
               q               <= '1;
               r               <= dividend;
               bus.div_by_zero <= 1'b1;
               state           <= OUT_Q;
               bus.out_valid   <= 1'b1;
               bus.out         <= '1;
            end else begin
               r        <= r_step;
               q        <= q_step;
               iter_cnt <= iter_cnt + 1'b1;
               if (iter_cnt == ICW'(WIDTH - 1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                  if (signed_q) state <= FIXUP; else
`endif
                  begin
                     state         <= OUT_Q;
                     bus.out_valid <= 1'b1;
                     bus.out       <= q_step;
                  end
               end
            end
`ifdef SEQ_DIVIDER_SIGNED_EN
            FIXUP: begin
               q             <= q_fix;
               r             <= r_fix;
               state         <= OUT_Q;
               bus.out_valid <= 1'b1;
               bus.out       <= q_fix;
            end
`endif
            OUT_Q: if (bus.out_ack) begin
               state          <= OUT_R;
               bus.out        <= r;
               bus.out_is_rem <= 1'b1;
            end
            OUT_R: if (bus.out_ack) begin
               state          <= IDLE;
               bus.out        <= '0;
               bus.out_valid  <= 1'b0;
               bus.out_is_rem <= 1'b0;
               bus.busy       <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_divider_byte_io.sv
// Randomized and directed bench for seq_divider_byte_io against an arithmetic reference model.
module tb_seq_divider_byte_io;
   localparam int WIDTH = 16;
   localparam int NB    = WIDTH / 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_divider_byte_io_if #(.WIDTH(WIDTH)) bus ();
   seq_divider_byte_io #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   int cmp_cnt  = 0;
   int fail_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit sm,
                        output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r, output bit dbz);
      logic signed [WIDTH-1:0] sa, sb;
      sa  = a;
      sb  = b;
      dbz = (b == 0);
      if (dbz) begin
         q = '1;
         r = a;
      end else if (sm && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) begin
         q = a;
         r = '0;
      end else if (sm) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   task automatic do_start(input bit sm);
`ifdef SEQ_DIVIDER_SIGNED_EN
      bus.signed_mode = sm;
`endif
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      bus.signed_mode = $urandom_range(0, 1);
`endif
   endtask

   task automatic send_ops(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int gap);
      logic [2*WIDTH-1:0] v;
      v = {b, a};
      for (int i = 0; i < 2 * NB; i++) begin
         bus.in_valid = 1'b1;
         bus.in       = v[i*8 +: 8];
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.in       = 8'($urandom);
         if (i != 2 * NB - 1) begin
            for (int g = 0; g < gap; g++) begin
               @(negedge clk);
               check("gap_no_valid", bus.out_valid, 0);
            end
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int gap, input int ack_wait, input bit sm, input bit noise);
      logic [WIDTH-1:0] eq, er;
      bit edbz;
      int cycles;
      int exp_lat;
      model(a, b, sm, eq, er, edbz);
      exp_lat = edbz ? 1 : (sm ? WIDTH + 1 : WIDTH);
      do_start(sm);
      check({tag, "_dbz_clr"}, bus.div_by_zero, 0);
      check({tag, "_busy"}, bus.busy, 1);
      send_ops(a, b, gap);
      cycles = 0;
      while (!bus.out_valid && cycles < 200) begin
         if (noise) bus.start = 1'($urandom);
         @(negedge clk);
         cycles++;
      end
      bus.start = 1'b0;
      check({tag, "_latency"}, cycles, exp_lat);
      check({tag, "_q"}, bus.out, eq);
      check({tag, "_q_flag"}, bus.out_is_rem, 0);
      check({tag, "_dbz"}, bus.div_by_zero, edbz);
      for (int w = 0; w < ack_wait; w++) begin
         if (noise) bus.start = 1'b1;
         @(negedge clk);
         check({tag, "_q_hold"}, {bus.out_valid, bus.out_is_rem, bus.out}, {2'b10, eq});
      end
      bus.out_ack = 1'b1;
      @(negedge clk);
      bus.out_ack = 1'b0;
      bus.start   = 1'b0;
      check({tag, "_r"}, bus.out, er);
      check({tag, "_r_flag"}, {bus.out_valid, bus.out_is_rem}, 2'b11);
      for (int w = 0; w < ack_wait; w++) begin
         @(negedge clk);
         check({tag, "_r_hold"}, {bus.out_valid, bus.out_is_rem, bus.out}, {2'b11, er});
      end
      bus.out_ack = 1'b1;
      if (noise) bus.start = 1'b1;
      @(negedge clk);
      bus.out_ack = 1'b0;
      bus.start   = 1'b0;
      check({tag, "_idle"}, {bus.busy, bus.out_valid, bus.out_is_rem, bus.out}, 0);
      check({tag, "_dbz_held"}, bus.div_by_zero, edbz);
      // Acknowledge with start high in OUT_R must not launch a new operation.
      @(negedge clk);
      check({tag, "_no_restart"}, bus.busy, 0);
   endtask

   initial begin
      logic [WIDTH-1:0] a, b;
      bit sm;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in       = 8'h00;
      bus.out_ack  = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      bus.signed_mode = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("reset_outputs",
            {bus.busy, bus.out_valid, bus.out_is_rem, bus.div_by_zero, bus.out}, 0);
      rst = 1'b0;
      bus.out_ack = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.out_ack = 1'b0;
      bus.in_valid = 1'b0;
      check("idle_ignores", {bus.busy, bus.out_valid}, 0);

      run_op("d1000_7", 16'd1000, 16'd7, 0, 0, 1'b0, 1'b0);
      run_op("dffff_1", 16'hFFFF, 16'h0001, 3, 0, 1'b0, 1'b0);
      run_op("d5_0", 16'd5, 16'd0, 0, 1, 1'b0, 1'b0);
      run_op("d3_10", 16'd3, 16'd10, 0, 5, 1'b0, 1'b1);

      do_start(1'b0);
      send_ops(16'd5000, 16'd7, 0);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_outputs",
            {bus.busy, bus.out_valid, bus.out_is_rem, bus.div_by_zero, bus.out}, 0);
      run_op("d100_9", 16'd100, 16'd9, 0, 0, 1'b0, 1'b0);

`ifdef SEQ_DIVIDER_SIGNED_EN
      run_op("s_m7_2", 16'hFFF9, 16'h0002, 0, 0, 1'b1, 1'b0);
      run_op("s_min_m1", 16'h8000, 16'hFFFF, 0, 0, 1'b1, 1'b0);
      run_op("s_m5_0", 16'hFFFB, 16'h0000, 0, 0, 1'b1, 1'b0);
`endif

      for (int n = 0; n < 40; n++) begin
         a = WIDTH'($urandom);
         case ($urandom_range(0, 7))
            0:       b = '0;
            1, 2, 3: b = WIDTH'($urandom_range(1, 15));
            default: b = WIDTH'($urandom);
         endcase
`ifdef SEQ_DIVIDER_SIGNED_EN
         sm = 1'($urandom_range(0, 1));
`else
         sm = 1'b0;
`endif
         run_op("rand", a, b, $urandom_range(0, 2), $urandom_range(0, 3), sm,
                1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
      $finish;
   end
endmodule
